exec_trace_buffer: RTL and testbench
====================================

EXEC_TRACE_BUFFER -- requirements
Module: exec_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of trace entries stored (power of two, 4..64).
REQ-002 SHALL have parameter ADDR_W, default 4, meaning log2(DEPTH).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port capture_en  input  1  sample the processor outputs this cycle.
REQ-006 SHALL have port pc_in  input  32  processor current PC value.
REQ-007 SHALL have port alu_in  input  32  processor ALU result.
REQ-008 SHALL have port mem_in  input  32  processor data-memory read value.
REQ-009 SHALL have port clear  input  1  synchronous flush of buffered entries and counters.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid trace word.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the presented word.
REQ-012 SHALL have port out_data  output  32  current trace word.
REQ-013 SHALL have port out_word  output  2  word index: 0 = PC, 1 = ALU, 2 = MEM.
REQ-014 SHALL have port out_last  output  1  high when out_word = 2.
REQ-015 SHALL have port level  output  ADDR_W+1  number of entries stored.
REQ-016 SHALL have ports full and empty  output  1 each  level = DEPTH / level = 0.
REQ-017 SHALL have port overflow  output  1  sticky: at least one capture dropped.
REQ-018 SHALL have port drop_count  output  16  dropped captures, saturating.

Function
REQ-019 SHALL store each accepted capture as one 96-bit entry {pc_in, alu_in, mem_in} in a circular buffer of DEPTH entries.
REQ-020 SHALL accept a capture (push) when capture_en = 1 and (full = 0 or a pop completes in the same cycle).
REQ-021 SHALL present the oldest entry serially as three words, PC then ALU then MEM, with out_word indicating which.
REQ-022 SHALL drive out_valid = ~empty; out_data, out_word and out_last SHALL be 0 when empty.
REQ-023 SHALL complete a word transfer when out_valid = 1 and out_ready = 1; the word index then advances 0->1->2->0.
REQ-024 SHALL pop the head entry on the transfer of word 2 (pop), advancing the read pointer modulo DEPTH.
REQ-025 SHALL hold out_data, out_word and out_last stable while out_valid = 1 and out_ready = 0.
REQ-026 SHALL make an entry captured at edge N visible (out_valid = 1, if previously empty) after edge N, i.e. one-cycle latency.
REQ-027 SHALL update level by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-028 SHALL advance the write pointer modulo DEPTH on push; wrap-around SHALL not disturb stored entries.
REQ-029 SHALL, when capture_en = 1, full = 1 and no pop occurs that cycle, drop the capture, set overflow and increment drop_count.
REQ-030 SHALL saturate drop_count at 0xFFFF; overflow SHALL remain set until reset or clear.
REQ-031 SHALL, on clear = 1, set pointers, word index, level, overflow and drop_count to 0 at the next edge; clear SHALL take priority over a same-cycle capture or transfer.
REQ-032 SHALL, on push to an empty buffer with out_ready = 1, not transfer that entry's word 0 in the same cycle (no fall-through).

Reset
REQ-033 SHALL, with reset = 1 at an edge, set out_valid 0, out_data 0, out_word 0, out_last 0, level 0, full 0, empty 1, overflow 0, drop_count 0.
REQ-034 SHALL, on reset mid-entry drain, abandon the partial entry; the word index SHALL restart at 0.
REQ-035 SHALL give reset priority over clear, capture_en and out_ready; storage contents need not be cleared.

Verification
REQ-036 SHALL verify single capture: pc_in=0x00400000, alu_in=0x5, mem_in=0xA, capture_en one cycle, out_ready=1 -> words 0x00400000, 0x5, 0xA with out_word 0,1,2, out_last only on third, then empty=1.
REQ-037 SHALL verify backpressure: out_ready=0 for 5 cycles with one entry -> out_data=PC word stable, out_valid=1, level=1 throughout.
REQ-038 SHALL verify fill/overflow: DEPTH=16, 20 captures with out_ready=0 -> full=1, level=16, overflow=1, drop_count=4; drained entries are the first 16 in order.
REQ-039 SHALL verify simultaneous push/pop when full: capture_en=1 on cycle where word 2 transfers -> capture accepted, level stays 16, drop_count unchanged.
REQ-040 SHALL verify wrap-around: 40 captures with continuous drain -> all 40 entries emerge in order, drop_count=0.
REQ-041 SHALL verify reset mid-drain: reset asserted after word 1 of entry with level=3 -> next edge level=0, empty=1, out_word=0, overflow=0.

Source files
------------

// File: rtl/exec_trace_buffer.sv
// rtl/exec_trace_buffer.sv - circular trace buffer of {pc, alu, mem} captures
// Entries are stored whole and drained as three serial words with valid/ready flow control.
module exec_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              capture_en,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       alu_in,
  input  logic [31:0]       mem_in,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [1:0]        out_word,
  output logic              out_last,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [15:0]       drop_count
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

  logic [95:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]        word_q, word_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_q, drop_d;

  logic        xfer, pop, push, drop;
  logic [95:0] head;

  assign full  = (level_q == FULL_LEVEL);
  assign empty = (level_q == '0);

  // A pop frees a slot in the same cycle, so a full buffer still accepts then.
  assign xfer = ~empty & out_ready;
  assign pop  = xfer & (word_q == 2'd2);
  assign push = capture_en & (~full | pop);
  assign drop = capture_en & full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    word_d     = word_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (xfer) begin
      word_d = (word_q == 2'd2) ? 2'd0 : word_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      word_d     = 2'd0;
      level_d    = '0;
      overflow_d = 1'b0;
      drop_d     = 16'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      word_q     <= 2'd0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= 16'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      word_q     <= word_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage is not reset; only entries between the pointers are ever presented.
  always_ff @(posedge clock) begin
    if (push && !reset && !clear) begin
      mem_q[wr_ptr_q] <= {pc_in, alu_in, mem_in};
    end
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    out_data = 32'd0;
    if (!empty) begin
      case (word_q)
        2'd0:    out_data = head[95:64];
        2'd1:    out_data = head[63:32];
        2'd2:    out_data = head[31:0];
        default: out_data = 32'd0;
      endcase
    end
  end

  assign out_valid  = ~empty;
  assign out_word   = empty ? 2'd0 : word_q;
  assign out_last   = ~empty & (word_q == 2'd2);
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_exec_trace_buffer.sv
// tb/tb_exec_trace_buffer.sv - scoreboard bench for exec_trace_buffer
// Driver updates a queue-based model; a negedge monitor compares every presented word.
module tb_exec_trace_buffer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clock = 1'b0;
  logic              reset, capture_en, clear, out_ready;
  logic [31:0]       pc_in, alu_in, mem_in;
  logic              out_valid, out_last, full, empty, overflow;
  logic [31:0]       out_data;
  logic [1:0]        out_word;
  logic [ADDR_W:0]   level;
  logic [15:0]       drop_count;

  exec_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .capture_en(capture_en),
    .pc_in(pc_in), .alu_in(alu_in), .mem_in(mem_in), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_word(out_word), .out_last(out_last), .level(level), .full(full),
    .empty(empty), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  word;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: number of stored entries, words already sent from the head entry.
  int m_size = 0, m_head = 0, m_drop = 0;
  bit m_ovf = 1'b0;
  int snap_level = 0, snap_drop = 0;
  bit snap_ovf = 1'b0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit cap, input bit rdy, input bit clr, input bit rst,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] mem);
    bit xfer, pop, acc, drp;
    capture_en = cap; out_ready = rdy; clear = clr; reset = rst;
    pc_in = pc; alu_in = alu; mem_in = mem;
    snap_level = m_size; snap_ovf = m_ovf; snap_drop = m_drop;
    xfer = (m_size > 0) && rdy;
    pop  = xfer && (m_head == 2);
    acc  = cap && ((m_size < DEPTH) || pop);
    drp  = cap && !acc;
    if (rst || clr) begin
      m_size = 0; m_head = 0; m_ovf = 1'b0; m_drop = 0;
      exp_q.delete();
    end else begin
      if (xfer) begin
        if (pop) begin
          m_head = 0;
          m_size--;
        end else begin
          m_head++;
        end
      end
      if (acc) begin
        m_size++;
        exp_q.push_back({pc, 2'd0});
        exp_q.push_back({alu, 2'd1});
        exp_q.push_back({mem, 2'd2});
      end
      if (drp) begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, rdy, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      chk("level", 32'(level), 32'(snap_level));
      chk("full", 32'(full), 32'(snap_level == DEPTH));
      chk("empty", 32'(empty), 32'(snap_level == 0));
      chk("out_valid", 32'(out_valid), 32'(snap_level != 0));
      chk("overflow", 32'(overflow), 32'(snap_ovf));
      chk("drop_count", 32'(drop_count), 32'(snap_drop));
      if (out_valid && !reset && !clear) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: DUT word 0x%0h with nothing expected", out_data);
        end else begin
          chk("out_data", out_data, exp_q[0].data);
          chk("out_word", 32'(out_word), 32'(exp_q[0].word));
          chk("out_last", 32'(out_last), 32'(exp_q[0].word == 2'd2));
          if (out_ready) void'(exp_q.pop_front());
        end
      end else if (!out_valid) begin
        chk("idle_data", out_data, 32'd0);
        chk("idle_word", 32'(out_word), 32'd0);
        chk("idle_last", 32'(out_last), 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b1; capture_en = 1'b0; clear = 1'b0; out_ready = 1'b0;
    pc_in = 32'd0; alu_in = 32'd0; mem_in = 32'd0;
    @(posedge clock);
    #1;
    mon_en = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);

    // Single capture, drained immediately.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0040_0000, 32'h5, 32'hA);
    chk("single_word0", out_data, 32'h0040_0000);
    idle(1'b1, 5);
    chk("single_empty", 32'(empty), 32'd1);

    // Backpressure holds the PC word.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h11, 32'h22);
    for (int k = 0; k < 5; k++) begin
      idle(1'b0, 1);
      chk("bp_data", out_data, 32'h1234_5678);
      chk("bp_level", 32'(level), 32'd1);
    end
    idle(1'b1, 4);

    // Fill past capacity, then push and pop together while full.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 20; i++)
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0000 + 32'(i * 4), $urandom, $urandom);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd16);
    chk("fill_ovf", 32'(overflow), 32'd1);
    chk("fill_drops", 32'(drop_count), 32'd4);
    idle(1'b1, 2);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'hCAFE_0000, 32'hBEEF, 32'hF00D);
    chk("pp_level", 32'(level), 32'd16);
    chk("pp_drops", 32'(drop_count), 32'd4);
    idle(1'b1, 60);
    chk("fill_drained", 32'(empty), 32'd1);

    // Wrap-around with continuous drain.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0080_0000 + 32'(i), $urandom, $urandom);
      idle(1'b1, 2);
    end
    idle(1'b1, 5);
    chk("wrap_drops", 32'(drop_count), 32'd0);
    chk("wrap_empty", 32'(empty), 32'd1);

    // Reset in the middle of draining an entry.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b0, 1'b0, 1'b0, $urandom, $urandom, $urandom);
    idle(1'b1, 2);
    chk("mid_level", 32'(level), 32'd3);
    chk("mid_word", 32'(out_word), 32'd2);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, $urandom, $urandom, $urandom);
    chk("rstmid_level", 32'(level), 32'd0);
    chk("rstmid_empty", 32'(empty), 32'd1);
    chk("rstmid_word", 32'(out_word), 32'd0);
    chk("rstmid_ovf", 32'(overflow), 32'd0);

    // Randomized traffic with occasional clear and reset.
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 75,
            $urandom_range(0, 299) == 0, $urandom_range(0, 499) == 0,
            $urandom, $urandom, $urandom);
    end
    idle(1'b1, 60);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
